// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver family.
// Also the home of the vote helper used by the receiver datapath.
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

    // ST_ prefix keeps ST_PARITY distinct from the PARITY module parameter.
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
    } state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] VOTE_LO    = 4'd7;
    localparam logic [3:0] VOTE_MID   = 4'd8;
    localparam logic [3:0] VOTE_HI    = 4'd9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_ex_if.sv
// Receive-side word stream: show-ahead head word plus valid/ready handshake.
interface uart_rx_ex_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (output data, valid, parity_err, frame_err, overrun, input ready);
    modport slave  (input data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every DIV enabled cycles.
module uart_baud_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cnt <= '0;
        else if (restart)  cnt <= '0;
        else if (en)       cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_ex.sv
// Parametrised UART receiver: 16x oversampling, 3-sample vote, parity/frame/break
// detection and a small show-ahead FIFO on the output side.
module uart_rx_ex import uart_pkg::*; #(
    parameter int      CLK_FREQ   = 100_000_000,
    parameter int      BAUD       = 9600,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_rx_ex_if.master    bus
);
    localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WW  = DATA_BITS + 2;

    logic [1:0] sync;
    logic       rx_s, rx_d, fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
            rx_d <= 1'b1;
        end else begin
            sync <= {sync[0], rx};
            rx_d <= sync[1];
        end
    end
    assign rx_s = sync[1];
    assign fall = rx_d & ~rx_s;

    state_e               state, state_n;
    logic                 restart, tick, en, push, maj, dec;
    logic                 last_data, last_stop;
    logic [3:0]           os_cnt, bit_cnt;
    logic                 s7, s8, perr, ferr, seen_one;
    logic [DATA_BITS-1:0] shreg;
    logic [WW-1:0]        word;

    assign en = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk(clk), .rst(rst), .en(en), .restart(restart), .tick(tick)
    );

    assign maj       = majority3(s7, s8, rx_s);
    assign dec       = tick && (os_cnt == VOTE_HI);
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
    assign word      = {ferr | ~maj, perr, shreg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        restart = 1'b0;
        push    = 1'b0;
        case (state)
            ST_IDLE:      if (fall) begin state_n = ST_START; restart = 1'b1; end
            ST_START:     if (dec) state_n = maj ? ST_IDLE : ST_DATA;
            ST_DATA:      if (dec && last_data) state_n = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY:    if (dec) state_n = ST_STOP;
            ST_STOP: if (dec && last_stop) begin
                push = 1'b1;
                // An all-zero frame is a break: hold off until the line idles again.
                state_n = (seen_one || maj) ? ST_IDLE : ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: if (rx_s) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    // os_cnt is 4 bits so it wraps at OVERSAMPLE on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            s7       <= 1'b1;
            s8       <= 1'b1;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            seen_one <= 1'b0;
        end else if (restart) begin
            os_cnt   <= '0;
            bit_cnt  <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            seen_one <= 1'b0;
        end else if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == VOTE_LO)  s7 <= rx_s;
            if (os_cnt == VOTE_MID) s8 <= rx_s;
            if (dec) begin
                bit_cnt  <= (state_n != state) ? 4'd0 : bit_cnt + 4'd1;
                seen_one <= seen_one | maj;
                case (state)
                    ST_DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
                    ST_PARITY: perr  <= (PARITY == PAR_EVEN) ? ^{shreg, maj} : ~^{shreg, maj};
                    ST_STOP:   ferr  <= ferr | ~maj;
                    default: ;
                endcase
            end
        end
    end

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [WW-1:0] head;
    logic          full, empty, pop, do_push, ovr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && bus.ready;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovr    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            ovr <= push && !do_push;
        end
    end

    assign bus.valid      = !empty;
    assign bus.data       = empty ? '0 : head[DATA_BITS-1:0];
    assign bus.parity_err = !empty && head[DATA_BITS];
    assign bus.frame_err  = !empty && head[DATA_BITS+1];
    assign bus.overrun    = ovr;
endmodule

// File: tb/tb_uart_rx_ex.sv
// Directed bench for uart_rx_ex: three configurations (8N1, 8E1, 9N2) on fast baud.
module tb_uart_rx_ex;
    import uart_pkg::*;

    localparam int CLK_FREQ = 640_000;
    localparam int BAUD     = 10_000;
    localparam int BT       = 64;   // DIV = 4, 16 ticks per bit

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] rx_l = 3'b111;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_ex_if #(.DATA_BITS(8)) if_a ();
    uart_rx_ex_if #(.DATA_BITS(8)) if_b ();
    uart_rx_ex_if #(.DATA_BITS(9)) if_c ();

    uart_rx_ex #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_l[0]), .bus(if_a));
    uart_rx_ex #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(PAR_EVEN)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_l[1]), .bus(if_b));
    uart_rx_ex #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(9), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .rx(rx_l[2]), .bus(if_c));

    // Popped words as {frame_err, parity_err, data9}
    logic [10:0] q0[$], q1[$], q2[$];
    int vc0 = 0, ov0 = 0;

    always @(negedge clk) begin
        if (if_a.valid) vc0++;
        if (if_a.overrun) ov0++;
        if (if_a.valid && if_a.ready) q0.push_back({if_a.frame_err, if_a.parity_err, 1'b0, if_a.data});
        if (if_b.valid && if_b.ready) q1.push_back({if_b.frame_err, if_b.parity_err, 1'b0, if_b.data});
        if (if_c.valid && if_c.ready) q2.push_back({if_c.frame_err, if_c.parity_err, if_c.data});
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [8:0] d, input int nb, input int pbit,
                        input int nstop, input logic sbit);
        rx_l[ch] = 1'b0; wait_cyc(BT);
        for (int i = 0; i < nb; i++) begin rx_l[ch] = d[i]; wait_cyc(BT); end
        if (pbit >= 0) begin rx_l[ch] = pbit[0]; wait_cyc(BT); end
        for (int i = 0; i < nstop; i++) begin rx_l[ch] = sbit; wait_cyc(BT); end
        rx_l[ch] = 1'b1;
    endtask

    task automatic test_reset;
        wait_cyc(3);
        @(negedge clk);
        n_cmp++; if (if_a.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", if_a.valid); end
        n_cmp++; if (if_a.data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", if_a.data); end
        n_cmp++; if (if_a.parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr got %b want 0", if_a.parity_err); end
        n_cmp++; if (if_a.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %b want 0", if_a.frame_err); end
        n_cmp++; if (if_a.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", if_a.overrun); end
        n_cmp++; if (if_c.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_c got %b want 0", if_c.valid); end
        rst = 1'b1;
        wait_cyc(2 * BT);
    endtask

    task automatic test_8n1;
        int base, vbase;
        logic [10:0] w;
        base = q0.size(); vbase = vc0;
        if_a.ready = 1'b1;
        send(0, 9'h0F0, 8, -1, 1, 1'b1);
        wait_cyc(2 * BT);
        @(negedge clk);
        n_cmp++; if (q0.size() - base !== 1) begin n_bad++; $display("FAIL 8n1_count got %0d want 1", q0.size() - base); end
        w = (q0.size() > base) ? q0[base] : 'x;
        n_cmp++; if (w !== 11'h0F0) begin n_bad++; $display("FAIL 8n1_word got %h want 0f0", w); end
        n_cmp++; if (vc0 - vbase !== 1) begin n_bad++; $display("FAIL 8n1_valid_cycles got %0d want 1", vc0 - vbase); end
        wait_cyc(1);
    endtask

    task automatic test_parity;
        int base;
        logic [10:0] w;
        base = q1.size();
        if_b.ready = 1'b1;
        send(1, 9'h0A5, 8, 1, 1, 1'b1);
        wait_cyc(BT);
        send(1, 9'h03C, 8, 0, 1, 1'b1);
        wait_cyc(2 * BT);
        @(negedge clk);
        n_cmp++; if (q1.size() - base !== 2) begin n_bad++; $display("FAIL par_count got %0d want 2", q1.size() - base); end
        w = (q1.size() > base) ? q1[base] : 'x;
        n_cmp++; if (w !== 11'h2A5) begin n_bad++; $display("FAIL par_bad_word got %h want 2a5", w); end
        w = (q1.size() > base + 1) ? q1[base+1] : 'x;
        n_cmp++; if (w !== 11'h03C) begin n_bad++; $display("FAIL par_good_word got %h want 03c", w); end
        wait_cyc(1);
    endtask

    task automatic test_break;
        int base;
        logic [10:0] w;
        base = q0.size();
        send(0, 9'h055, 8, -1, 1, 1'b0);
        wait_cyc(2 * BT);
        rx_l[0] = 1'b0;
        wait_cyc(20 * BT);
        @(negedge clk);
        n_cmp++; if (q0.size() - base !== 2) begin n_bad++; $display("FAIL brk_count_low got %0d want 2", q0.size() - base); end
        wait_cyc(1);
        rx_l[0] = 1'b1;
        wait_cyc(3 * BT);
        @(negedge clk);
        n_cmp++; if (q0.size() - base !== 2) begin n_bad++; $display("FAIL brk_count got %0d want 2", q0.size() - base); end
        w = (q0.size() > base) ? q0[base] : 'x;
        n_cmp++; if (w !== 11'h455) begin n_bad++; $display("FAIL brk_stop0_word got %h want 455", w); end
        w = (q0.size() > base + 1) ? q0[base+1] : 'x;
        n_cmp++; if (w !== 11'h400) begin n_bad++; $display("FAIL brk_word got %h want 400", w); end
        wait_cyc(1);
    endtask

    task automatic test_false_start;
        int base;
        logic [10:0] w;
        base = q0.size();
        rx_l[0] = 1'b0;
        wait_cyc(12);
        rx_l[0] = 1'b1;
        wait_cyc(2 * BT);
        @(negedge clk);
        n_cmp++; if (q0.size() - base !== 0) begin n_bad++; $display("FAIL fs_no_push got %0d want 0", q0.size() - base); end
        wait_cyc(1);
        send(0, 9'h081, 8, -1, 1, 1'b1);
        wait_cyc(2 * BT);
        @(negedge clk);
        w = (q0.size() > base) ? q0[base] : 'x;
        n_cmp++; if (w !== 11'h081) begin n_bad++; $display("FAIL fs_next_word got %h want 081", w); end
        wait_cyc(1);
    endtask

    task automatic test_overrun;
        int base, obase;
        logic [10:0] w;
        if_a.ready = 1'b0;
        base = q0.size(); obase = ov0;
        for (int k = 1; k <= 5; k++) begin
            send(0, 9'(k), 8, -1, 1, 1'b1);
            wait_cyc(BT);
        end
        @(negedge clk);
        n_cmp++; if (ov0 - obase !== 1) begin n_bad++; $display("FAIL ovr_pulses got %0d want 1", ov0 - obase); end
        n_cmp++; if (if_a.valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid got %b want 1", if_a.valid); end
        n_cmp++; if (if_a.data !== 8'h01) begin n_bad++; $display("FAIL ovr_head got %h want 01", if_a.data); end
        wait_cyc(1);
        if_a.ready = 1'b1;
        wait_cyc(8);
        @(negedge clk);
        n_cmp++; if (q0.size() - base !== 4) begin n_bad++; $display("FAIL ovr_count got %0d want 4", q0.size() - base); end
        for (int k = 0; k < 4; k++) begin
            w = (q0.size() > base + k) ? q0[base+k] : 'x;
            n_cmp++; if (w !== 11'(k + 1)) begin n_bad++; $display("FAIL ovr_word%0d got %h want %h", k, w, 11'(k + 1)); end
        end
        n_cmp++; if (if_a.valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drained got %b want 0", if_a.valid); end
        wait_cyc(1);
    endtask

    task automatic test_reset_midframe;
        int base;
        logic [10:0] w;
        base = q2.size();
        if_c.ready = 1'b1;
        send(2, 9'h1AB, 9, -1, 2, 1'b1);
        wait_cyc(2 * BT);
        @(negedge clk);
        w = (q2.size() > base) ? q2[base] : 'x;
        n_cmp++; if (w !== 11'h1AB) begin n_bad++; $display("FAIL rm_first_word got %h want 1ab", w); end
        wait_cyc(1);
        if_c.ready = 1'b0;
        rx_l[2] = 1'b0; wait_cyc(BT);
        rx_l[2] = 1'b1; wait_cyc(BT);
        rx_l[2] = 1'b0; wait_cyc(20);
        rst = 1'b0; rx_l[2] = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (if_c.valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid_after got %b want 0", if_c.valid); end
        wait_cyc(BT);
        if_c.ready = 1'b1;
        wait_cyc(3 * BT);
        @(negedge clk);
        n_cmp++; if (q2.size() - base !== 1) begin n_bad++; $display("FAIL rm_no_push got %0d want 1", q2.size() - base); end
        wait_cyc(1);
        send(2, 9'h0FF, 9, -1, 2, 1'b1);
        wait_cyc(2 * BT);
        @(negedge clk);
        w = (q2.size() > base + 1) ? q2[base+1] : 'x;
        n_cmp++; if (w !== 11'h0FF) begin n_bad++; $display("FAIL rm_next_word got %h want 0ff", w); end
    endtask

    initial begin
        if_a.ready = 1'b0;
        if_b.ready = 1'b0;
        if_c.ready = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_break();
        test_false_start();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
